serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes `DIGIT` operand bits per clock through a registered carry, so it trades latency for area against a flat `WIDTH`-bit adder. It is the sequential, width-generic successor to the single-bit `fulladder` cell. It sits in datapaths where an add or subtract can take `WIDTH/DIGIT` cycles and is handled through a start/done handshake.

---
 rtl/serial_adder.sv | 172 +++++++++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered carry,
// with a start/busy/done handshake and registered sum, carry-out and overflow.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ripple of full-adder slices; returns {carry_out, carry_into_top_slice, sum}.
    function automatic logic [DIGIT+1:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             ci
    );
        logic [DIGIT-1:0] sum;
        logic [DIGIT:0]   cv;
        sum   = '0;
        cv    = '0;
        cv[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = x[i] ^ y[i] ^ cv[i];
            cv[i+1]  = (x[i] & y[i]) | (cv[i] & (x[i] ^ y[i]));
        end
        return {cv[DIGIT], cv[DIGIT-1], sum};
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic             ovf_r;

    logic             busy_next_s;
    logic             done_next_s;
    logic             load_s;
    logic             last_s;
    logic [DIGIT+1:0] dig_s;
    logic [DIGIT-1:0] dig_sum_s;
    logic             dig_co_s;
    logic             dig_cmsb_s;
    logic [WIDTH-1:0] next_sum_s;

    assign dig_s      = digit_add(opa_r[DIGIT-1:0], opb_r[DIGIT-1:0], carry_r);
    assign dig_sum_s  = dig_s[DIGIT-1:0];
    assign dig_cmsb_s = dig_s[DIGIT];
    assign dig_co_s   = dig_s[DIGIT+1];
    // New digit enters at the top so the LSB digit ends up at bit 0 after N shifts.
    assign next_sum_s = (sum_r >> DIGIT) | (WIDTH'(dig_sum_s) << (WIDTH - DIGIT));
    assign last_s     = (cnt_r == CW'(N - 1));
    assign load_s     = (state_r != RUN) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE:    next_state_s = start  ? RUN  : IDLE;
            RUN:     next_state_s = last_s ? DONE : RUN;
            DONE:    next_state_s = start  ? RUN  : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs, decoded from the state being entered so they can be registered.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (next_state_s)
            RUN:     busy_next_s = 1'b1;
            DONE:    done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Operand shifters, carry, digit counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r   <= '0;
            opb_r   <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            s_r     <= '0;
            c_r     <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (load_s) begin
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            sum_r   <= '0;
            carry_r <= cin;
            cnt_r   <= '0;
        end else if (state_r == RUN) begin
            opa_r   <= opa_r >> DIGIT;
            opb_r   <= opb_r >> DIGIT;
            sum_r   <= next_sum_s;
            carry_r <= dig_co_s;
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
                s_r   <= next_sum_s;
                c_r   <= dig_co_s;
                ovf_r <= dig_cmsb_s ^ dig_co_s;
            end else begin
                s_r   <= s_r;
                c_r   <= c_r;
                ovf_r <= ovf_r;
            end
        end else begin
            opa_r   <= opa_r;
            opb_r   <= opb_r;
            sum_r   <= sum_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign c    = c_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an arithmetic/timing model checked every cycle against an
// 8-bit/1-digit and a 16-bit/4-digit instance, plus hand-computed directed results.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmp_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic        busy8, done8, c8, ovf8;
    logic [7:0]  s8;

    logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        busy16, done16, c16, ovf16;
    logic [15:0] s16;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .s(s8), .c(c8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .s(s16), .c(c16), .ovf(ovf16)
    );

    // Model state: expected outputs plus the result pending for the operation in flight.
    logic        mb8 = 1'b0, md8 = 1'b0, mc8 = 1'b0, mo8 = 1'b0, pc8 = 1'b0, po8 = 1'b0;
    logic [7:0]  ms8 = 8'h00, ps8 = 8'h00;
    int          rem8 = 0;
    logic        mb16 = 1'b0, md16 = 1'b0, mc16 = 1'b0, mo16 = 1'b0, pc16 = 1'b0, po16 = 1'b0;
    logic [15:0] ms16 = 16'h0000, ps16 = 16'h0000;
    int          rem16 = 0;

    // 8-bit model: result is plain arithmetic, timing is "busy for N cycles then one done cycle".
    always @(posedge clk) begin : model8
        logic [8:0] r;
        logic [7:0] bb;
        md8 = 1'b0;
        if (rst) begin
            mb8 = 1'b0; ms8 = 8'h00; mc8 = 1'b0; mo8 = 1'b0; rem8 = 0;
        end else if (mb8) begin
            rem8 = rem8 - 1;
            if (rem8 == 0) begin
                mb8 = 1'b0; md8 = 1'b1; ms8 = ps8; mc8 = pc8; mo8 = po8;
            end
        end else if (start8) begin
            bb  = sub8 ? ~b8 : b8;
            r   = {1'b0, a8} + {1'b0, bb} + {8'h00, cin8};
            ps8 = r[7:0];
            pc8 = r[8];
            po8 = (a8[7] == bb[7]) && (r[7] != a8[7]);
            mb8 = 1'b1;
            rem8 = 8;
        end
    end

    // 16-bit model, four digits per operation.
    always @(posedge clk) begin : model16
        logic [16:0] r;
        logic [15:0] bb;
        md16 = 1'b0;
        if (rst) begin
            mb16 = 1'b0; ms16 = 16'h0000; mc16 = 1'b0; mo16 = 1'b0; rem16 = 0;
        end else if (mb16) begin
            rem16 = rem16 - 1;
            if (rem16 == 0) begin
                mb16 = 1'b0; md16 = 1'b1; ms16 = ps16; mc16 = pc16; mo16 = po16;
            end
        end else if (start16) begin
            bb   = sub16 ? ~b16 : b16;
            r    = {1'b0, a16} + {1'b0, bb} + {16'h0000, cin16};
            ps16 = r[15:0];
            pc16 = r[16];
            po16 = (a16[15] == bb[15]) && (r[15] != a16[15]);
            mb16 = 1'b1;
            rem16 = 4;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 1;
            if ({busy8, done8, s8, c8, ovf8} !== {mb8, md8, ms8, mc8, mo8}) begin
                failures = failures + 1;
                $display("FAIL cycle8 t=%0t actual busy=%b done=%b s=%h c=%b ovf=%b required busy=%b done=%b s=%h c=%b ovf=%b",
                         $time, busy8, done8, s8, c8, ovf8, mb8, md8, ms8, mc8, mo8);
            end
            checks = checks + 1;
            if ({busy16, done16, s16, c16, ovf16} !== {mb16, md16, ms16, mc16, mo16}) begin
                failures = failures + 1;
                $display("FAIL cycle16 t=%0t actual busy=%b done=%b s=%h c=%b ovf=%b required busy=%b done=%b s=%h c=%b ovf=%b",
                         $time, busy16, done16, s16, c16, ovf16, mb16, md16, ms16, mc16, mo16);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one request for a single edge; returns in the first busy cycle.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Wait (bounded) for done8; k0 is the cycle index after the accepting edge we are in now.
    task automatic wait_done8(input int k0, output int lat, output int nbusy);
        int k;
        k = k0;
        nbusy = 0;
        while (!done8 && k < 30) begin
            nbusy = nbusy + int'(busy8);
            @(negedge clk);
            k = k + 1;
        end
        if (!done8) chk("timeout8", 32'(k), 32'd9);
        lat = k;
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat, nb;
        start_op8(a, b, ci, sb);
        wait_done8(1, lat, nb);
        chk({name, "_lat"}, 32'(lat), 32'd9);
        chk({name, "_busy"}, 32'(nb), 32'd8);
        chk({name, "_s"}, {24'h0, s8}, {24'h0, es});
        chk({name, "_c_ovf"}, {30'h0, c8, ovf8}, {30'h0, ec, eo});
        @(negedge clk);
    endtask

    initial begin
        int lat, nb, k, ndone;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_state", {20'h0, busy8, done8, s8, c8, ovf8}, 32'h0);
        chk("reset_state16", {12'h0, busy16, done16, s16, c16, ovf16}, 32'h0);

        op8("wrap",     8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("ovf_add",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("ovf_sub",  8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("borrow",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("plain",    8'h3C, 8'h21, 1'b1, 1'b0, 8'h5E, 1'b0, 1'b0);

        // Handshake: ignored start while busy, then accepted start in the done cycle.
        start_op8(8'h05, 8'h07, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(4, lat, nb);
        chk("hs_first_lat", 32'(lat), 32'd9);
        chk("hs_first_s", {23'h0, s8, c8}, {23'h0, 8'hFE, 1'b0});
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("hs_hold_s", {24'h0, s8}, 32'h0000_00FE);
        chk("hs_busy_again", {31'h0, busy8}, 32'd1);
        wait_done8(1, lat, nb);
        chk("hs_second_lat", 32'(lat), 32'd9);
        chk("hs_second_s", {22'h0, s8, c8, ovf8}, {22'h0, 8'h80, 1'b0, 1'b1});
        @(negedge clk);

        // Reset during the fourth RUN cycle aborts with no done.
        start_op8(8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort", {21'h0, busy8, done8, s8, c8, ovf8}, 32'h0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            ndone = ndone + int'(done8);
            @(negedge clk);
        end
        chk("rst_no_done", 32'(ndone), 32'd0);

        // 16-bit, 4-bit digits: random operations, latency 5.
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); sub16 = 1'($urandom);
            start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            k = 1;
            while (!done16 && k < 20) begin
                @(negedge clk);
                k = k + 1;
            end
            chk("lat16", 32'(k), 32'd5);
            @(negedge clk);
        end
        // One directed 16-bit subtract to pin the model: 0x1234 - 0x4321 = 0xCF13, borrow.
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; sub16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        chk("sub16_s", {13'h0, done16, s16, c16, ovf16}, {13'h0, 1'b1, 16'hCF13, 1'b0, 1'b0});
        @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
